// File: rtl/cpu_pkg.sv
// Shared constants for the mini CPU datapath.
// Word width, ALU opcodes and bus source select codes.
package cpu_pkg;

  localparam int WORD_W = 32;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_SHR  = 5'b00100;
  localparam logic [4:0] ALU_SHRA = 5'b00101;
  localparam logic [4:0] ALU_SHL  = 5'b00110;
  localparam logic [4:0] ALU_ROR  = 5'b00111;
  localparam logic [4:0] ALU_ROL  = 5'b01000;
  localparam logic [4:0] ALU_MUL  = 5'b01001;
  localparam logic [4:0] ALU_DIV  = 5'b01010;
  localparam logic [4:0] ALU_NEG  = 5'b01011;
  localparam logic [4:0] ALU_NOT  = 5'b01100;
  localparam logic [4:0] ALU_INC  = 5'b01101;

  // Bus sources 0..15 are R0..R15; the rest follow.
  typedef logic [4:0] bus_sel_t;
  localparam int       NUM_SRC  = 24;
  localparam bus_sel_t SEL_HI   = 5'd16;
  localparam bus_sel_t SEL_LO   = 5'd17;
  localparam bus_sel_t SEL_ZH   = 5'd18;
  localparam bus_sel_t SEL_ZL   = 5'd19;
  localparam bus_sel_t SEL_PC   = 5'd20;
  localparam bus_sel_t SEL_MDR  = 5'd21;
  localparam bus_sel_t SEL_INP  = 5'd22;
  localparam bus_sel_t SEL_Y    = 5'd23;
  localparam bus_sel_t SEL_NONE = 5'd24;

endpackage

// File: rtl/alu.sv
// Combinational ALU: A op B into a 64-bit result.
// Ports: A, B, op in; result out.
module alu
  import cpu_pkg::*;
(
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  input  logic [4:0]        op,
  output logic [63:0]       result
);

  logic [4:0]         sh;
  logic signed [63:0] ma, mb;
  logic signed [31:0] da, db;
  logic [63:0]        dbl;

  assign sh  = B[4:0];
  assign ma  = {{32{A[31]}}, A};
  assign mb  = {{32{B[31]}}, B};
  assign da  = A;
  assign db  = B;
  assign dbl = {A, A};

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result[31:0] = A + B;
      ALU_SUB:  result[31:0] = A - B;
      ALU_AND:  result[31:0] = A & B;
      ALU_OR:   result[31:0] = A | B;
      ALU_SHR:  result[31:0] = A >> sh;
      ALU_SHRA: result[31:0] = da >>> sh;
      ALU_SHL:  result[31:0] = A << sh;
      ALU_ROR:  result = 64'(dbl >> sh) & 64'hFFFF_FFFF;
      ALU_ROL:  result[31:0] = 32'((dbl << sh) >> 32);
      ALU_MUL:  result = ma * mb;
      ALU_DIV: begin
        // Divide by zero: quotient 0, remainder A.
        if (B == '0) begin
          result[63:32] = A;
        end else begin
          result[31:0]  = da / db;
          result[63:32] = da % db;
        end
      end
      ALU_NEG:  result[31:0] = -B;
      ALU_NOT:  result[31:0] = ~B;
      ALU_INC:  result[31:0] = B + 32'd1;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/reg32.sv
// Generic 32-bit register with synchronous clear and load enable.
// Ports: clk, clear, en, d, q.
module reg32
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic              en,
  input  logic [WORD_W-1:0] d,
  output logic [WORD_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clear)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/data_path.sv
// Bus datapath: R0-R15, HI, LO, Z, PC, MDR, InPort, Y on one shared bus.
// Strobes select the bus driver, enables load registers, ALU feeds Z.
module data_path
  import cpu_pkg::*;
(
  input  logic        Clock,
  input  logic        clear,
  input  logic        Read,
  input  logic [4:0]  op,
  input  logic [31:0] Mdatain,
  input  logic        R0out, R1out, R2out, R3out,
  input  logic        R4out, R5out, R6out, R7out,
  input  logic        R8out, R9out, R10out, R11out,
  input  logic        R12out, R13out, R14out, R15out,
  input  logic        HIout, LOout, Zhighout, Zlowout,
  input  logic        PCout, MDRout, InPortout, Yout,
  input  logic        R0in, R1in, R2in, R3in,
  input  logic        R4in, R5in, R6in, R7in,
  input  logic        R8in, R9in, R10in, R11in,
  input  logic        R12in, R13in, R14in, R15in,
  input  logic        HIin, LOin, ZHighin, Zlowin,
  input  logic        InPC, MDRin, InPortin, Yin,
  output logic [31:0] BusOut,
  output logic [31:0] mdrData,
  output logic [31:0] BusMuxInR0, BusMuxInR1,
  output logic [31:0] BusMuxInR2, BusMuxInR3,
  output logic [31:0] BusMuxInR4, BusMuxInR5,
  output logic [31:0] BusMuxInR6, BusMuxInR7,
  output logic [31:0] BusMuxInR8, BusMuxInR9,
  output logic [31:0] BusMuxInR10, BusMuxInR11,
  output logic [31:0] BusMuxInR12, BusMuxInR13,
  output logic [31:0] BusMuxInR14, BusMuxInR15,
  output logic [31:0] BusMuxInZhigh,
  output logic [31:0] BusMuxInZlow,
  output logic [31:0] BusMuxInPCout,
  output logic [31:0] BusMuxInInPortout,
  output logic [31:0] BusMuxInYout,
  output logic [31:0] BusMuxInHI,
  output logic [31:0] BusMuxInLO
);

  logic [15:0]       r_out, r_in;
  logic [31:0]       r_q [16];
  logic [NUM_SRC-1:0] strobe;
  logic [31:0]       src [NUM_SRC];
  bus_sel_t          sel;
  logic [63:0]       res;
  logic [31:0]       hi_q, lo_q, zh_q, zl_q;
  logic [31:0]       pc_q, mdr_q, inp_q, y_q;
  logic [31:0]       mdr_d;

  assign r_out = {R15out, R14out, R13out, R12out,
                  R11out, R10out, R9out, R8out,
                  R7out, R6out, R5out, R4out,
                  R3out, R2out, R1out, R0out};
  assign r_in  = {R15in, R14in, R13in, R12in,
                  R11in, R10in, R9in, R8in,
                  R7in, R6in, R5in, R4in,
                  R3in, R2in, R1in, R0in};

  assign strobe = {Yout, InPortout, MDRout, PCout,
                   Zlowout, Zhighout, LOout, HIout,
                   r_out};

  for (genvar i = 0; i < 16; i++) begin : g_gpr
    reg32 u_r (
      .clk(Clock), .clear(clear), .en(r_in[i]),
      .d(BusOut), .q(r_q[i])
    );
    assign src[i] = r_q[i];
  end

  assign src[SEL_HI]  = hi_q;
  assign src[SEL_LO]  = lo_q;
  assign src[SEL_ZH]  = zh_q;
  assign src[SEL_ZL]  = zl_q;
  assign src[SEL_PC]  = pc_q;
  assign src[SEL_MDR] = mdr_q;
  assign src[SEL_INP] = inp_q;
  assign src[SEL_Y]   = y_q;

  // Encoder: lowest-numbered strobe wins (R0 highest).
  always_comb begin
    sel = SEL_NONE;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (strobe[i]) sel = bus_sel_t'(i);
  end

  always_comb begin
    BusOut = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (sel == bus_sel_t'(i)) BusOut = src[i];
  end

  alu u_alu (.A(y_q), .B(BusOut), .op(op), .result(res));

  assign mdr_d = Read ? Mdatain : BusOut;

  reg32 u_hi  (.clk(Clock), .clear(clear), .en(HIin),
               .d(BusOut), .q(hi_q));
  reg32 u_lo  (.clk(Clock), .clear(clear), .en(LOin),
               .d(BusOut), .q(lo_q));
  reg32 u_zh  (.clk(Clock), .clear(clear), .en(ZHighin),
               .d(res[63:32]), .q(zh_q));
  reg32 u_zl  (.clk(Clock), .clear(clear), .en(Zlowin),
               .d(res[31:0]), .q(zl_q));
  reg32 u_pc  (.clk(Clock), .clear(clear), .en(InPC),
               .d(BusOut), .q(pc_q));
  reg32 u_mdr (.clk(Clock), .clear(clear), .en(MDRin),
               .d(mdr_d), .q(mdr_q));
  reg32 u_inp (.clk(Clock), .clear(clear), .en(InPortin),
               .d(BusOut), .q(inp_q));
  reg32 u_y   (.clk(Clock), .clear(clear), .en(Yin),
               .d(BusOut), .q(y_q));

  assign mdrData           = mdr_q;
  assign BusMuxInR0        = r_q[0];
  assign BusMuxInR1        = r_q[1];
  assign BusMuxInR2        = r_q[2];
  assign BusMuxInR3        = r_q[3];
  assign BusMuxInR4        = r_q[4];
  assign BusMuxInR5        = r_q[5];
  assign BusMuxInR6        = r_q[6];
  assign BusMuxInR7        = r_q[7];
  assign BusMuxInR8        = r_q[8];
  assign BusMuxInR9        = r_q[9];
  assign BusMuxInR10       = r_q[10];
  assign BusMuxInR11       = r_q[11];
  assign BusMuxInR12       = r_q[12];
  assign BusMuxInR13       = r_q[13];
  assign BusMuxInR14       = r_q[14];
  assign BusMuxInR15       = r_q[15];
  assign BusMuxInZhigh     = zh_q;
  assign BusMuxInZlow      = zl_q;
  assign BusMuxInPCout     = pc_q;
  assign BusMuxInInPortout = inp_q;
  assign BusMuxInYout      = y_q;
  assign BusMuxInHI        = hi_q;
  assign BusMuxInLO        = lo_q;

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path.
// Register transfers, ALU ops, bus priority and clear.
module tb_data_path;

  localparam int HI = 16, LO = 17, ZH = 18, ZL = 19;
  localparam int PC = 20, MDR = 21, INP = 22, Y = 23;

  logic        Clock = 1'b0;
  logic        clear, Read;
  logic [4:0]  op;
  logic [31:0] Mdatain;
  logic [23:0] outs, ins;
  logic [31:0] bus, mdr;
  logic [31:0] r [16];
  logic [31:0] zh, zl, pc, inp, y, hi, lo;

  int vecs = 0;
  int errs = 0;

  always #5 Clock = ~Clock;

  data_path dut (
    .Clock(Clock), .clear(clear), .Read(Read),
    .op(op), .Mdatain(Mdatain),
    .R0out(outs[0]), .R1out(outs[1]),
    .R2out(outs[2]), .R3out(outs[3]),
    .R4out(outs[4]), .R5out(outs[5]),
    .R6out(outs[6]), .R7out(outs[7]),
    .R8out(outs[8]), .R9out(outs[9]),
    .R10out(outs[10]), .R11out(outs[11]),
    .R12out(outs[12]), .R13out(outs[13]),
    .R14out(outs[14]), .R15out(outs[15]),
    .HIout(outs[HI]), .LOout(outs[LO]),
    .Zhighout(outs[ZH]), .Zlowout(outs[ZL]),
    .PCout(outs[PC]), .MDRout(outs[MDR]),
    .InPortout(outs[INP]), .Yout(outs[Y]),
    .R0in(ins[0]), .R1in(ins[1]),
    .R2in(ins[2]), .R3in(ins[3]),
    .R4in(ins[4]), .R5in(ins[5]),
    .R6in(ins[6]), .R7in(ins[7]),
    .R8in(ins[8]), .R9in(ins[9]),
    .R10in(ins[10]), .R11in(ins[11]),
    .R12in(ins[12]), .R13in(ins[13]),
    .R14in(ins[14]), .R15in(ins[15]),
    .HIin(ins[HI]), .LOin(ins[LO]),
    .ZHighin(ins[ZH]), .Zlowin(ins[ZL]),
    .InPC(ins[PC]), .MDRin(ins[MDR]),
    .InPortin(ins[INP]), .Yin(ins[Y]),
    .BusOut(bus), .mdrData(mdr),
    .BusMuxInR0(r[0]), .BusMuxInR1(r[1]),
    .BusMuxInR2(r[2]), .BusMuxInR3(r[3]),
    .BusMuxInR4(r[4]), .BusMuxInR5(r[5]),
    .BusMuxInR6(r[6]), .BusMuxInR7(r[7]),
    .BusMuxInR8(r[8]), .BusMuxInR9(r[9]),
    .BusMuxInR10(r[10]), .BusMuxInR11(r[11]),
    .BusMuxInR12(r[12]), .BusMuxInR13(r[13]),
    .BusMuxInR14(r[14]), .BusMuxInR15(r[15]),
    .BusMuxInZhigh(zh), .BusMuxInZlow(zl),
    .BusMuxInPCout(pc), .BusMuxInInPortout(inp),
    .BusMuxInYout(y), .BusMuxInHI(hi),
    .BusMuxInLO(lo)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    outs = '0;
    ins  = '0;
    Read = 1'b0;
  endtask

  task automatic ld_mdr(input logic [31:0] v);
    Mdatain  = v;
    Read     = 1'b1;
    ins[MDR] = 1'b1;
    tick();
  endtask

  task automatic xfer(input int s, input int d);
    outs[s] = 1'b1;
    ins[d]  = 1'b1;
    tick();
  endtask

  task automatic set_reg(input int d,
                         input logic [31:0] v);
    ld_mdr(v);
    xfer(MDR, d);
  endtask

  task automatic alu_z(input logic [4:0] o,
                       input int s);
    op      = o;
    outs[s] = 1'b1;
    ins[ZH] = 1'b1;
    ins[ZL] = 1'b1;
    tick();
  endtask

  initial begin
    outs    = '0;
    ins     = '0;
    Read    = 1'b0;
    op      = 5'd0;
    Mdatain = '0;
    clear   = 1'b1;
    @(posedge Clock);
    #1;
    clear = 1'b0;

    chk("rst_r0", r[0], 32'h0);
    chk("rst_r15", r[15], 32'h0);
    chk("rst_zl", zl, 32'h0);
    chk("rst_mdr", mdr, 32'h0);
    chk("rst_bus", bus, 32'h0);

    // ROR
    set_reg(Y, 32'hFFFF_FFF4);
    chk("y_load", y, 32'hFFFF_FFF4);
    set_reg(2, 32'd5);
    alu_z(5'b00111, 2);
    xfer(ZL, 1);
    xfer(ZH, 0);
    chk("ror_r1", r[1], 32'hA7FF_FFFF);
    chk("ror_r0", r[0], 32'h0);

    // ROL: 0xFFFFFFF4 rol 5
    alu_z(5'b01000, 2);
    chk("rol_zl", zl, 32'hFFFF_FE9F);

    // MUL -3 * 7
    set_reg(Y, 32'hFFFF_FFFD);
    set_reg(3, 32'd7);
    alu_z(5'b01001, 3);
    chk("mul_zh", zh, 32'hFFFF_FFFF);
    chk("mul_zl", zl, 32'hFFFF_FFEB);

    // DIV
    set_reg(Y, 32'd17);
    set_reg(6, 32'd5);
    alu_z(5'b01010, 6);
    chk("div_zl", zl, 32'd3);
    chk("div_zh", zh, 32'd2);
    alu_z(5'b01010, 7);
    chk("div0_zl", zl, 32'd0);
    chk("div0_zh", zh, 32'd17);

    // Zlowin alone leaves ZH alone
    op      = 5'b00000;
    outs[6] = 1'b1;
    ins[ZL] = 1'b1;
    tick();
    chk("add_zl", zl, 32'd22);
    chk("add_zh_kept", zh, 32'd17);

    alu_z(5'b00001, 6);
    chk("sub_zl", zl, 32'd12);
    alu_z(5'b01011, 6);
    chk("neg_zl", zl, 32'hFFFF_FFFB);
    alu_z(5'b01100, 6);
    chk("not_zl", zl, 32'hFFFF_FFFA);
    alu_z(5'b00010, 6);
    chk("and_zl", zl, 32'd1);
    alu_z(5'b00011, 6);
    chk("or_zl", zl, 32'd21);
    alu_z(5'b00110, 6);
    chk("shl_zl", zl, 32'd544);
    alu_z(5'b01111, 6);
    chk("bad_op_zl", zl, 32'd0);

    // ADD wraps
    set_reg(Y, 32'hFFFF_FFFF);
    set_reg(8, 32'd2);
    alu_z(5'b00000, 8);
    chk("add_wrap_zl", zl, 32'd1);
    chk("add_wrap_zh", zh, 32'd0);

    // Bus priority and idle
    set_reg(4, 32'h11);
    set_reg(9, 32'h22);
    outs[4] = 1'b1;
    outs[9] = 1'b1;
    #1;
    chk("prio_bus", bus, 32'h11);
    outs = '0;
    outs[HI] = 1'b1;
    outs[Y]  = 1'b1;
    #1;
    chk("prio_hi_y", bus, 32'h0);
    outs = '0;
    outs[9] = 1'b1;
    outs[Y] = 1'b1;
    #1;
    chk("prio_r9_y", bus, 32'h22);
    outs = '0;
    #1;
    chk("idle_bus", bus, 32'h0);

    // MDR from bus when Read low
    xfer(9, MDR);
    chk("mdr_bus", mdr, 32'h22);

    // Same register read and written
    op       = 5'b01101;
    outs[ZL] = 1'b1;
    ins[ZL]  = 1'b1;
    #1;
    chk("rw_old", bus, 32'd1);
    tick();
    chk("rw_new", zl, 32'd2);

    // SHRA vs SHR
    set_reg(Y, 32'h8000_0000);
    set_reg(8, 32'd4);
    alu_z(5'b00101, 8);
    chk("shra_zl", zl, 32'hF800_0000);
    alu_z(5'b00100, 8);
    chk("shr_zl", zl, 32'h0800_0000);
    chk("shr_zh", zh, 32'h0);

    // Other registers load from bus
    xfer(8, HI);
    xfer(9, LO);
    xfer(4, INP);
    chk("hi_load", hi, 32'd4);
    chk("lo_load", lo, 32'h22);
    chk("inp_load", inp, 32'h11);

    // Synchronous clear
    set_reg(5, 32'h1234);
    set_reg(PC, 32'h40);
    clear    = 1'b1;
    ins[5]   = 1'b1;
    outs[MDR] = 1'b1;
    #1;
    chk("pre_clr_r5", r[5], 32'h1234);
    chk("pre_clr_pc", pc, 32'h40);
    tick();
    clear = 1'b0;
    for (int i = 0; i < 16; i++)
      chk($sformatf("clr_r%0d", i), r[i], 32'h0);
    chk("clr_hi", hi, 32'h0);
    chk("clr_lo", lo, 32'h0);
    chk("clr_zh", zh, 32'h0);
    chk("clr_zl", zl, 32'h0);
    chk("clr_pc", pc, 32'h0);
    chk("clr_inp", inp, 32'h0);
    chk("clr_y", y, 32'h0);
    chk("clr_mdr", mdr, 32'h0);

    // Loads work again after clear
    set_reg(11, 32'hCAFE_0001);
    chk("post_clr_r11", r[11], 32'hCAFE_0001);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
